// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - frame format constants, CRC polynomial and receiver FSM states
package bus_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 64;
  localparam int CRC_W     = 4;
  localparam int NODES     = 1 << ADDR_W;
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W + CRC_W;

  // low bits of x^4+x+1; the x^4 term is implied by the shift out of the MSB
  localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CRC  = 2'd3
  } rx_state_e;

  // one MSB-first step of the CRC register: no reflection, no final XOR
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/bus_frame_receiver_if.sv
// rtl/bus_frame_receiver_if.sv - one-entry valid/ready output buffer handshake of the frame receiver
interface bus_frame_receiver_if;
  import bus_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_crc_ok;

  // the receiver produces frames, the sink consumes them
  modport master (output out_valid, output out_addr, output out_data, output out_crc_ok,
                  input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, input out_crc_ok,
                  output out_ready);
endinterface

// File: rtl/bus_frame_receiver_crc4_serial.sv
// rtl/bus_frame_receiver_crc4_serial.sv - bit-serial CRC-4 (x^4+x+1), shared by transmitter and receiver
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] remainder
);

  logic [CRC_W-1:0] r_crc;

  // clear wins over enable so a start bit can restart the register in one edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '0;
    end else if (clear) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= crc_step(r_crc, bit_in);
    end
  end

  assign remainder = r_crc;

endmodule

// File: rtl/bus_frame_receiver.sv
// rtl/bus_frame_receiver.sv - serial bus frame deserializer with CRC check, output buffer and node strobes (optional RX_STATS_EN counters)
module bus_frame_receiver
  import bus_pkg::*;
#(
  parameter bit DROP_BAD_CRC = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  bus_in,
  bus_frame_receiver_if.master  out_if,
  output logic [NODES-1:0]      node_strobe,
  output logic                  overrun,
  output logic                  busy
`ifdef RX_STATS_EN
  ,
  output logic [15:0]           stat_ok,
  output logic [15:0]           stat_bad,
  output logic [15:0]           stat_ovr
`endif
);

  localparam logic [5:0] LAST_ADDR = 6'(ADDR_W - 1);
  localparam logic [5:0] LAST_DATA = 6'(DATA_W - 1);
  localparam logic [5:0] LAST_CRC  = 6'(CRC_W - 1);

  rx_state_e         r_state;
  logic [5:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr_sr;
  logic [DATA_W-1:0] r_data_sr;
  logic [CRC_W-2:0]  r_crc_sr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_crc_ok;
  logic [NODES-1:0]  r_strobe;
  logic              r_ovr;

  logic [CRC_W-1:0]  w_crc_rem;
  logic [CRC_W-1:0]  w_rx_crc;
  logic              w_crc_clr;
  logic              w_crc_en;
  logic              w_last;
  logic              w_good;
  logic              w_accept;
  logic              w_room;
  logic              w_drain;

  // the start bit resets the CRC; only addr+data bits feed it
  assign w_crc_clr = (r_state == IDLE) && bus_in;
  assign w_crc_en  = (r_state == ADDR) || (r_state == DATA);

  crc4_serial u_crc (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (w_crc_clr),
    .enable    (w_crc_en),
    .bit_in    (bus_in),
    .remainder (w_crc_rem)
  );

  // the last CRC bit is compared straight off the line so completion needs no extra cycle
  assign w_rx_crc = {r_crc_sr, bus_in};
  assign w_last   = (r_state == CRC) && (r_cnt == LAST_CRC);
  assign w_good   = (w_rx_crc == w_crc_rem);
  assign w_accept = w_good || !DROP_BAD_CRC;
  assign w_drain  = r_valid && out_if.out_ready;
  assign w_room   = !r_valid || out_if.out_ready;

  // frame FSM, shift registers, output buffer and one-cycle pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr_sr <= '0;
      r_data_sr <= '0;
      r_crc_sr  <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_crc_ok  <= 1'b0;
      r_strobe  <= '0;
      r_ovr     <= 1'b0;
    end else begin
      r_strobe <= '0;
      r_ovr    <= 1'b0;
      if (w_drain) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (bus_in) begin
            r_state <= ADDR;
            r_cnt   <= '0;
          end
        end
        ADDR: begin
          r_addr_sr <= {r_addr_sr[ADDR_W-2:0], bus_in};
          if (r_cnt == LAST_ADDR) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DATA: begin
          r_data_sr <= {r_data_sr[DATA_W-2:0], bus_in};
          if (r_cnt == LAST_DATA) begin
            r_state <= CRC;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        CRC: begin
          r_crc_sr <= w_rx_crc[CRC_W-2:0];
          if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (w_accept) begin
              if (w_room) begin
                r_valid  <= 1'b1;
                r_addr   <= r_addr_sr;
                r_data   <= r_data_sr;
                r_crc_ok <= w_good;
                if (w_good) begin
                  r_strobe <= NODES'(1) << r_addr_sr;
                end
              end else begin
                r_ovr <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign out_if.out_valid  = r_valid;
  assign out_if.out_addr   = r_addr;
  assign out_if.out_data   = r_data;
  assign out_if.out_crc_ok = r_crc_ok;
  assign node_strobe       = r_strobe;
  assign overrun           = r_ovr;
  assign busy              = (r_state != IDLE);

`ifdef RX_STATS_EN
  logic [15:0] r_stat_ok;
  logic [15:0] r_stat_bad;
  logic [15:0] r_stat_ovr;

  // saturating per-outcome frame counters, updated on the completion edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ok  <= '0;
      r_stat_bad <= '0;
      r_stat_ovr <= '0;
    end else if (w_last) begin
      if (w_good && (r_stat_ok != 16'hFFFF)) begin
        r_stat_ok <= r_stat_ok + 16'd1;
      end
      if (!w_good && (r_stat_bad != 16'hFFFF)) begin
        r_stat_bad <= r_stat_bad + 16'd1;
      end
      if (w_accept && !w_room && (r_stat_ovr != 16'hFFFF)) begin
        r_stat_ovr <= r_stat_ovr + 16'd1;
      end
    end
  end

  assign stat_ok  = r_stat_ok;
  assign stat_bad = r_stat_bad;
  assign stat_ovr = r_stat_ovr;
`endif

endmodule
